ddr_wr_ctrl: RTL and testbench

DDR_WR_CTRL -- requirements
Module: ddr_wr_ctrl

---
 rtl/ddr_wr_ctrl.sv | 146 ++++++++++++++
 tb/tb_ddr_wr_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_wr_ctrl.sv
// DDR write controller: buffers user writes in a small FIFO and issues each one as a
// single-beat write with independent command and write-data handshakes.
module ddr_wr_ctrl #(
  parameter int DW    = 512,
  parameter int AW    = 30,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          wr_req_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          wr_full_o,
  output logic          wr_idle_o,
  input  logic          ddr_rdy_i,
  input  logic          ddr_wdf_rdy_i,
  output logic          ddr_en_o,
  output logic [2:0]    ddr_cmd_o,
  output logic [AW-1:0] ddr_addr_o,
  output logic          ddr_wdf_wren_o,
  output logic          ddr_wdf_end_o,
  output logic [DW-1:0] ddr_wdf_data_o
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [AW+DW-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [PW:0]      count_r;
  logic             cmd_done_r, dat_done_r;
  logic             cmd_done_nxt_s, dat_done_nxt_s;
  logic [AW-1:0]    addr_r;
  logic [DW-1:0]    data_r;
  logic             empty_s, full_s, push_s, pop_s;
  logic             cmd_acc_s, dat_acc_s, both_s;

  assign full_s    = (count_r == (PW+1)'(DEPTH));
  assign empty_s   = (count_r == (PW+1)'(0));
  assign push_s    = wr_req_i & ~full_s;

  assign ddr_en_o       = (state_r == ISSUE) & ~cmd_done_r;
  assign ddr_wdf_wren_o = (state_r == ISSUE) & ~dat_done_r;
  assign ddr_wdf_end_o  = ddr_wdf_wren_o;
  assign ddr_cmd_o      = 3'b000;
  assign ddr_addr_o     = addr_r;
  assign ddr_wdf_data_o = data_r;
  assign wr_full_o      = full_s;
  assign wr_idle_o      = (state_r == IDLE) & empty_s;

  assign cmd_acc_s = ddr_en_o & ddr_rdy_i;
  assign dat_acc_s = ddr_wdf_wren_o & ddr_wdf_rdy_i;
  // Both halves count as done when finished earlier or accepted this very cycle.
  assign both_s    = (cmd_done_r | cmd_acc_s) & (dat_done_r | dat_acc_s);

  // Next-state, head pop and handshake-flag logic.
  always_comb begin
    state_nxt_s    = state_r;
    pop_s          = 1'b0;
    cmd_done_nxt_s = cmd_done_r;
    dat_done_nxt_s = dat_done_r;
    case (state_r)
      IDLE: begin
        cmd_done_nxt_s = 1'b0;
        dat_done_nxt_s = 1'b0;
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (both_s) begin
          cmd_done_nxt_s = 1'b0;
          dat_done_nxt_s = 1'b0;
          if (!empty_s) begin
            pop_s       = 1'b1;
            state_nxt_s = ISSUE;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          cmd_done_nxt_s = cmd_done_r | cmd_acc_s;
          dat_done_nxt_s = dat_done_r | dat_acc_s;
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        cmd_done_nxt_s = 1'b0;
        dat_done_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state and handshake flags.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r    <= IDLE;
      cmd_done_r <= 1'b0;
      dat_done_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cmd_done_r <= cmd_done_nxt_s;
      dat_done_r <= dat_done_nxt_s;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= (PW+1)'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) mem_r[wr_ptr_r] <= {wr_addr_i, wr_data_i};
  end

  // Output stage holds the current write stable until both halves are accepted.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_r <= {AW{1'b0}};
      data_r <= {DW{1'b0}};
    end else if (pop_s) begin
      {addr_r, data_r} <= mem_r[rd_ptr_r];
    end
  end

endmodule

// File: tb/tb_ddr_wr_ctrl.sv
// Self-checking bench for ddr_wr_ctrl: directed scenarios drive a scoreboard that a
// negedge monitor drains whenever the DDR side accepts a command or a data beat.
module tb_ddr_wr_ctrl;

  localparam int DW = 512;
  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          wr_req_i;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_full_o, wr_idle_o;
  logic          ddr_rdy_i, ddr_wdf_rdy_i;
  logic          ddr_en_o, ddr_wdf_wren_o, ddr_wdf_end_o;
  logic [2:0]    ddr_cmd_o;
  logic [AW-1:0] ddr_addr_o;
  logic [DW-1:0] ddr_wdf_data_o;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];

  ddr_wr_ctrl #(.DW(DW), .AW(AW), .DEPTH(4)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn_i),
    .wr_req_i      (wr_req_i),
    .wr_addr_i     (wr_addr_i),
    .wr_data_i     (wr_data_i),
    .wr_full_o     (wr_full_o),
    .wr_idle_o     (wr_idle_o),
    .ddr_rdy_i     (ddr_rdy_i),
    .ddr_wdf_rdy_i (ddr_wdf_rdy_i),
    .ddr_en_o      (ddr_en_o),
    .ddr_cmd_o     (ddr_cmd_o),
    .ddr_addr_o    (ddr_addr_o),
    .ddr_wdf_wren_o(ddr_wdf_wren_o),
    .ddr_wdf_end_o (ddr_wdf_end_o),
    .ddr_wdf_data_o(ddr_wdf_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [7:0] b);
    mk = {64{b}};
  endfunction

  task automatic sb_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"},    ddr_en_o,       1'b0);
    chk({tag, "_wren"},  ddr_wdf_wren_o, 1'b0);
    chk({tag, "_end"},   ddr_wdf_end_o,  1'b0);
    chk({tag, "_full"},  wr_full_o,      1'b0);
    chk({tag, "_cmd"},   ddr_cmd_o,      3'b000);
    chk({tag, "_addr"},  ddr_addr_o,     {AW{1'b0}});
    chk({tag, "_data"},  ddr_wdf_data_o, {DW{1'b0}});
    chk({tag, "_idle"},  wr_idle_o,      1'b1);
  endtask

  // Scoreboard monitor: every accepted command/data beat must match the oldest expected write.
  always @(negedge clk) begin
    if (rstn_i) begin
      chk("end_eq_wren", ddr_wdf_end_o, ddr_wdf_wren_o);
      if (ddr_en_o && ddr_rdy_i) begin
        if (exp_addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_cmd got addr=%0h want=no command", ddr_addr_o);
        end else begin
          chk("cmd_addr", ddr_addr_o, exp_addr_q.pop_front());
          chk("cmd_code", ddr_cmd_o, 3'b000);
        end
      end
      if (ddr_wdf_wren_o && ddr_wdf_rdy_i) begin
        if (exp_data_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_data got=%0h want=no beat", ddr_wdf_data_o[63:0]);
        end else begin
          chk("wdf_data", ddr_wdf_data_o, exp_data_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rstn_i = 1'b0; wr_req_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    ddr_rdy_i = 1'b0; ddr_wdf_rdy_i = 1'b0;
    #2;
    chk_reset("por");
    @(posedge clk); #1;
    rstn_i = 1'b1;
    step();

    // Single write, both readies high.
    ddr_rdy_i = 1'b1; ddr_wdf_rdy_i = 1'b1;
    wr_req_i = 1'b1; wr_addr_i = 30'h100; wr_data_i = mk(8'hA5);
    sb_push(30'h100, mk(8'hA5));
    step();
    wr_req_i = 1'b0;
    chk("single_e0_en", ddr_en_o, 1'b0);
    chk("single_e0_idle", wr_idle_o, 1'b0);
    step();
    chk("single_e1_en",   ddr_en_o,       1'b1);
    chk("single_e1_wren", ddr_wdf_wren_o, 1'b1);
    chk("single_e1_end",  ddr_wdf_end_o,  1'b1);
    chk("single_e1_addr", ddr_addr_o,     30'h100);
    chk("single_e1_cmd",  ddr_cmd_o,      3'b000);
    step();
    chk("single_e2_en",   ddr_en_o,       1'b0);
    chk("single_e2_wren", ddr_wdf_wren_o, 1'b0);
    chk("single_e2_idle", wr_idle_o,      1'b1);

    // Command back-pressure for 5 cycles, data accepted immediately.
    ddr_rdy_i = 1'b0; ddr_wdf_rdy_i = 1'b1;
    wr_req_i = 1'b1; wr_addr_i = 30'h200; wr_data_i = mk(8'h3C);
    sb_push(30'h200, mk(8'h3C));
    step();
    wr_req_i = 1'b0;
    step();
    for (int i = 1; i <= 6; i++) begin
      chk("bp_en",   ddr_en_o,       1'b1);
      chk("bp_addr", ddr_addr_o,     30'h200);
      chk("bp_wren", ddr_wdf_wren_o, (i == 1) ? 1'b1 : 1'b0);
      if (i == 6) ddr_rdy_i = 1'b1;
      step();
    end
    chk("bp_done_en",   ddr_en_o,       1'b0);
    chk("bp_done_wren", ddr_wdf_wren_o, 1'b0);
    chk("bp_done_idle", wr_idle_o,      1'b1);

    // Data accepted first, command 3 cycles later.
    ddr_rdy_i = 1'b0; ddr_wdf_rdy_i = 1'b1;
    wr_req_i = 1'b1; wr_addr_i = 30'h300; wr_data_i = mk(8'h5A);
    sb_push(30'h300, mk(8'h5A));
    step();
    wr_req_i = 1'b0;
    step();
    for (int i = 1; i <= 4; i++) begin
      chk("df_en",   ddr_en_o,       1'b1);
      chk("df_wren", ddr_wdf_wren_o, (i == 1) ? 1'b1 : 1'b0);
      if (i == 4) ddr_rdy_i = 1'b1;
      step();
    end
    chk("df_done_en",   ddr_en_o,       1'b0);
    chk("df_done_wren", ddr_wdf_wren_o, 1'b0);

    // Fill: one write parks in the output stage, four fill the FIFO, the sixth drops.
    ddr_rdy_i = 1'b0; ddr_wdf_rdy_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wr_req_i = 1'b1; wr_addr_i = 30'h400 + 30'(k); wr_data_i = mk(8'h10 + 8'(k));
      if (k < 5) sb_push(30'h400 + 30'(k), mk(8'h10 + 8'(k)));
      step();
      chk("fill_full", wr_full_o, (k >= 4) ? 1'b1 : 1'b0);
    end
    wr_req_i = 1'b0; ddr_rdy_i = 1'b1;
    for (int c = 0; c < 40 && !wr_idle_o; c++) step();
    chk("fill_drain_idle", wr_idle_o, 1'b1);
    chk("fill_q_empty", DW'(exp_addr_q.size()), DW'(0));

    // Streaming: eight back-to-back writes issue on consecutive cycles.
    ddr_rdy_i = 1'b1; ddr_wdf_rdy_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wr_req_i = 1'b1; wr_addr_i = 30'h500 + 30'(k); wr_data_i = mk(8'h80 + 8'(k));
      sb_push(30'h500 + 30'(k), mk(8'h80 + 8'(k)));
      step();
      chk("stream_full", wr_full_o, 1'b0);
      if (k >= 1) begin
        chk("stream_en",   ddr_en_o,   1'b1);
        chk("stream_addr", ddr_addr_o, 30'h500 + 30'(k - 1));
      end
    end
    wr_req_i = 1'b0;
    step();
    chk("stream_last_en",   ddr_en_o,   1'b1);
    chk("stream_last_addr", ddr_addr_o, 30'h507);
    step();
    chk("stream_end_en",   ddr_en_o,  1'b0);
    chk("stream_end_idle", wr_idle_o, 1'b1);

    // Reset mid-burst: pending writes are discarded and nothing issues afterwards.
    ddr_rdy_i = 1'b0; ddr_wdf_rdy_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_req_i = 1'b1; wr_addr_i = 30'h600 + 30'(k); wr_data_i = mk(8'hC0 + 8'(k));
      step();
    end
    wr_req_i = 1'b0;
    chk("mid_busy_en", ddr_en_o, 1'b1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk_reset("mid");
    @(posedge clk); #1;
    rstn_i = 1'b1; ddr_rdy_i = 1'b1; ddr_wdf_rdy_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("post_rst_en",   ddr_en_o,       1'b0);
      chk("post_rst_wren", ddr_wdf_wren_o, 1'b0);
    end

    chk("final_addr_q", DW'(exp_addr_q.size()), DW'(0));
    chk("final_data_q", DW'(exp_data_q.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
